// File: rtl/perceptron_pkg.sv
// rtl/perceptron_pkg.sv - width helpers and saturation for the perceptron MAC datapath
package perceptron_pkg;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int rest;
        result = 0;
        rest = value - 1;
        while (rest > 0) begin
            result = result + 1;
            rest = rest >> 1;
        end
        return result;
    endfunction

    // Exact width of an unsigned-activation times signed-weight product.
    function automatic int p_width(input int a_width, input int b_width);
        return a_width + b_width;
    endfunction

    // Accumulator width: product width plus headroom for vector_len terms and sign.
    function automatic int acc_width(input int a_width, input int b_width, input int vector_len);
        return p_width(a_width, b_width) + clog2(vector_len) + 1;
    endfunction

    // Clamp a signed value to the range representable in out_width bits.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] value, input int out_width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_width - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/perceptron_mul_pipe.sv
// rtl/perceptron_mul_pipe.sv - NUM_STAGE-deep unsigned x signed multiplier with valid chain
module perceptron_mul_pipe
    import perceptron_pkg::*;
#(
    parameter int A_WIDTH   = 20,
    parameter int B_WIDTH   = 7,
    parameter int NUM_STAGE = 4,
    localparam int P_WIDTH  = p_width(A_WIDTH, B_WIDTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ce,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [A_WIDTH-1:0]        a,
    input  logic signed [B_WIDTH-1:0] b,
    output logic                      out_valid,
    output logic signed [P_WIDTH-1:0] product
);

    logic [A_WIDTH-1:0]        a_r;
    logic signed [B_WIDTH-1:0] b_r;
    logic                      v_r;
    logic signed [P_WIDTH-1:0] p_r [NUM_STAGE-1];
    logic [NUM_STAGE-2:0]      v_p;
    logic signed [P_WIDTH-1:0] prod_c;

    // Activation is zero-extended so the multiply is a plain signed DSP operation.
    assign prod_c = P_WIDTH'($signed({1'b0, a_r})) * P_WIDTH'(b_r);

    // Input register, then NUM_STAGE-1 product registers; flush only kills valids.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r <= '0;
            b_r <= '0;
            v_r <= 1'b0;
            v_p <= '0;
            for (int i = 0; i < NUM_STAGE - 1; i++) begin
                p_r[i] <= '0;
            end
        end else begin
            if (ce) begin
                a_r    <= a;
                b_r    <= b;
                p_r[0] <= prod_c;
                for (int i = 1; i < NUM_STAGE - 1; i++) begin
                    p_r[i] <= p_r[i-1];
                end
            end
            if (flush) begin
                v_r <= 1'b0;
                v_p <= '0;
            end else if (ce) begin
                v_r    <= in_valid;
                v_p[0] <= v_r;
                for (int i = 1; i < NUM_STAGE - 1; i++) begin
                    v_p[i] <= v_p[i-1];
                end
            end
        end
    end

    assign out_valid = v_p[NUM_STAGE-2];
    assign product   = p_r[NUM_STAGE-2];

endmodule

// File: rtl/perceptron_mac_pipe.sv
// rtl/perceptron_mac_pipe.sv - pipelined dot-product MAC; PERCEPTRON_MAC_SAT_EN enables output clamping
module perceptron_mac_pipe
    import perceptron_pkg::*;
#(
    parameter int A_WIDTH    = 20,
    parameter int B_WIDTH    = 7,
    parameter int NUM_STAGE  = 4,
    parameter int VECTOR_LEN = 16,
    parameter int OUT_WIDTH  = 26
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [A_WIDTH-1:0]          a,
    input  logic signed [B_WIDTH-1:0]   b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] result
);

    localparam int P_WIDTH   = p_width(A_WIDTH, B_WIDTH);
    localparam int ACC_WIDTH = acc_width(A_WIDTH, B_WIDTH, VECTOR_LEN);
    localparam int CNT_WIDTH = (clog2(VECTOR_LEN) > 0) ? clog2(VECTOR_LEN) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(VECTOR_LEN - 1);

    logic                          stall;
    logic                          prod_valid;
    logic signed [P_WIDTH-1:0]     product;
    logic signed [ACC_WIDTH-1:0]   prod_ext;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic signed [ACC_WIDTH-1:0]   sum;
    logic signed [OUT_WIDTH-1:0]   final_sum;
    logic [CNT_WIDTH-1:0]          cnt;

    // A held, unaccepted result freezes the whole datapath.
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall & ~clear;

    perceptron_mul_pipe #(
        .A_WIDTH   (A_WIDTH),
        .B_WIDTH   (B_WIDTH),
        .NUM_STAGE (NUM_STAGE)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .ce        (~stall),
        .flush     (clear),
        .in_valid  (in_valid & in_ready),
        .a         (a),
        .b         (b),
        .out_valid (prod_valid),
        .product   (product)
    );

    assign prod_ext = ACC_WIDTH'(product);
    assign sum      = (cnt == '0) ? prod_ext : acc + prod_ext;

`ifdef PERCEPTRON_MAC_SAT_EN
    assign final_sum = OUT_WIDTH'(saturate(64'(sum), OUT_WIDTH));
`else
    assign final_sum = OUT_WIDTH'(sum);
`endif

    // Term counting, accumulation and the registered result handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            acc       <= '0;
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (clear) begin
                cnt <= '0;
                acc <= '0;
            end else if (!stall && prod_valid) begin
                acc <= sum;
                if (cnt == LAST) begin
                    cnt       <= '0;
                    result    <= final_sum;
                    out_valid <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_perceptron_mac_pipe.sv
// tb/tb_perceptron_mac_pipe.sv - randomized and directed bench against a dot-product reference model
module tb_perceptron_mac_pipe;

    localparam int AW = 20;
    localparam int BW = 7;
    localparam int NS = 4;
    localparam int VL = 16;
    localparam int OW = 26;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 clear;
    logic                 in_valid;
    logic                 in_ready;
    logic [AW-1:0]        a;
    logic signed [BW-1:0] b;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] result;

    logic                 in_valid1;
    logic                 in_ready1;
    logic [AW-1:0]        a1;
    logic signed [BW-1:0] b1;
    logic                 out_valid1;
    logic signed [OW-1:0] result1;

    int checks = 0;
    int errors = 0;

    longint cur_sum;
    int     cur_n;
    longint exp_q[$];
    longint got_log[$];
    int     due1_q[$];
    longint val1_q[$];
    int     cyc = 0;
    int     last_acc;
    int     first_ov;
    int     ov_cnt;
    int     low_cnt;
    bit     accepted;
    bit     first1 = 1'b1;
    bit     seen1 = 1'b0;
    longint res1_first = 0;

    perceptron_mac_pipe #(
        .A_WIDTH(AW), .B_WIDTH(BW), .NUM_STAGE(NS), .VECTOR_LEN(VL), .OUT_WIDTH(OW)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    perceptron_mac_pipe #(
        .A_WIDTH(AW), .B_WIDTH(BW), .NUM_STAGE(2), .VECTOR_LEN(1), .OUT_WIDTH(OW)
    ) dut1 (
        .clk(clk), .reset(reset), .clear(1'b0), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(1'b1), .result(result1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint fit(input longint s);
`ifdef PERCEPTRON_MAC_SAT_EN
        longint hi;
        longint lo;
        hi = (longint'(1) << (OW - 1)) - 1;
        lo = -hi - 1;
        return (s > hi) ? hi : ((s < lo) ? lo : s);
`else
        logic signed [OW-1:0] t;
        t = s[OW-1:0];
        return longint'(t);
`endif
    endfunction

    // One clock: observe just before the rising edge, update the model, return at the falling edge.
    task automatic cycle();
        #4;
        check("in_ready", in_ready, !(out_valid && !out_ready) && !clear);
        accepted = in_valid && in_ready;
        if (accepted) begin
            cur_sum += longint'(a) * longint'(b);
            cur_n++;
            last_acc = cyc;
            if (cur_n == VL) begin
                exp_q.push_back(fit(cur_sum));
                cur_sum = 0;
                cur_n = 0;
            end
        end
        if (out_valid) begin
            if (first_ov < 0) first_ov = cyc;
            ov_cnt++;
        end
        if (!in_ready) low_cnt++;
        if (out_valid && out_ready) begin
            check("have_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                check("result", result, exp_q.pop_front());
                got_log.push_back(longint'(result));
            end
        end
        if (clear) begin
            cur_sum = 0;
            cur_n = 0;
        end
        if (in_valid1 && in_ready1) begin
            due1_q.push_back(cyc + 3);
            val1_q.push_back(fit(longint'(a1) * longint'(b1)));
        end
        if (due1_q.size() > 0 && due1_q[0] == cyc) begin
            check("v1_valid", out_valid1, 1);
            check("v1_result", result1, val1_q[0]);
            if (!seen1) begin
                res1_first = longint'(result1);
                seen1 = 1'b1;
            end
            void'(due1_q.pop_front());
            void'(val1_q.pop_front());
        end else begin
            check("v1_idle", out_valid1, 0);
        end
        cyc++;
        @(negedge clk);
        if (first1) begin
            first1 = 1'b0;
            in_valid1 = 1'b0;
        end else begin
            in_valid1 = ($urandom_range(0, 1) == 1);
            a1 = AW'($urandom);
            b1 = BW'($urandom);
        end
    endtask

    task automatic send(input logic [AW-1:0] av, input logic signed [BW-1:0] bv);
        int n = 0;
        in_valid = 1'b1;
        a = av;
        b = bv;
        do begin
            cycle();
            n++;
        end while (!accepted && n < 200);
        if (!accepted) check("send_timeout", n, 0);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && n < 100) begin
            cycle();
            n++;
        end
        check("drain", exp_q.size(), 0);
        idle(2);
    endtask

    task automatic stall_test();
        low_cnt = 0;
        got_log.delete();
        fork
            begin
                for (int i = 0; i < 16; i++) send(2, 3);
                for (int i = 0; i < 16; i++) send(1, -1);
            end
            begin
                int n = 0;
                while (!out_valid && n < 300) begin
                    @(negedge clk);
                    n++;
                end
                out_ready = 1'b0;
                repeat (5) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();
        check("t3_in_ready_low", low_cnt, 5);
        check("t3_count", got_log.size(), 2);
        if (got_log.size() == 2) begin
            check("t3_first", got_log[0], 96);
            check("t3_second", got_log[1], -16);
        end
    endtask

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        in_valid1 = 1'b0;
        a1 = '0;
        b1 = '0;
        cur_sum = 0;
        cur_n = 0;
        first_ov = -1;
        ov_cnt = 0;
        last_acc = 0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        reset = 1'b0;
        check("rst_in_ready", in_ready, 1);

        // directed VECTOR_LEN=1 term, plus ramp vector on the main instance
        in_valid1 = 1'b1;
        a1 = 1000;
        b1 = -7;
        got_log.delete();
        for (int i = 1; i <= 16; i++) send(AW'(i), 1);
        idle(NS + 4);
        check("t1_latency", first_ov - last_acc, NS + 1);
        check("t1_ov_cycles", ov_cnt, 1);
        check("t1_count", got_log.size(), 1);
        if (got_log.size() > 0) check("t1_sum", got_log[0], 136);

        // extreme operands: wrap or clamp
        got_log.delete();
        for (int i = 0; i < 16; i++) send(20'hFFFFF, -64);
        drain();
        check("t2_count", got_log.size(), 1);
`ifdef PERCEPTRON_MAC_SAT_EN
        if (got_log.size() > 0) check("t2_sat", got_log[0], -33554432);
`else
        if (got_log.size() > 0) check("t2_wrap", got_log[0], 1024);
`endif

        stall_test();

        // clear discards a partial vector
        got_log.delete();
        for (int i = 0; i < 7; i++) send(AW'($urandom), BW'($urandom));
        clear = 1'b1;
        in_valid = 1'b1;
        a = 9;
        b = 9;
        cycle();
        clear = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) send(5, 5);
        drain();
        check("t4_count", got_log.size(), 1);
        if (got_log.size() > 0) check("t4_sum", got_log[0], 400);

        // reset with a held result and terms in flight
        got_log.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 19; i++) send(AW'($urandom), BW'($urandom));
        idle(NS + 2);
        check("t5_held", out_valid, 1);
        reset = 1'b1;
        #1;
        check("t5_out_valid", out_valid, 0);
        check("t5_result", result, 0);
        exp_q.delete();
        due1_q.delete();
        val1_q.delete();
        cur_sum = 0;
        cur_n = 0;
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        check("t5_in_ready", in_ready, 1);
        for (int i = 0; i < 16; i++) send(1, 1);
        drain();
        check("t5_count", got_log.size(), 1);
        if (got_log.size() > 0) check("t5_sum", got_log[0], 16);

        // random traffic with random backpressure
        for (int i = 0; i < 600; i++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            a = AW'($urandom);
            b = BW'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end
        drain();
        check("v1_first", res1_first, -7000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/perceptron_mac_pipe.md
# perceptron_mac_pipe

Parametrised pipelined multiply-accumulate engine for the perceptron datapath. It computes a VECTOR_LEN-term dot product of unsigned activations and signed weights, one term per cycle, and emits one result per vector. It generalises the fixed 20×7 four-stage DSP multiplier with configurable widths, pipeline depth, accumulation, valid/ready flow control and optional output saturation. It sits between the activation/weight fetch logic and the perceptron activation function.

## Interface
- A_WIDTH, 20, unsigned activation width
- B_WIDTH, 7, signed weight width
- NUM_STAGE, 4, multiplier pipeline depth in cycles (≥2)
- VECTOR_LEN, 16, terms per dot product (≥1)
- OUT_WIDTH, 26, signed result width (≤ ACC_WIDTH)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- clear  in  1  synchronous flush of partial sum and in-flight terms
- in_valid  in  1  term present on a/b
- in_ready  out  1  term accepted when in_valid & in_ready
- a  in  A_WIDTH  unsigned activation
- b  in  B_WIDTH  signed weight
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- result  out  OUT_WIDTH  signed dot product

## Operation
- Product: $signed({1'b0,a}) * $signed(b), P_WIDTH = A_WIDTH+B_WIDTH bits, exact.
- Accumulator: ACC_WIDTH = P_WIDTH + clog2(VECTOR_LEN)+1, sign-extended adds; never overflows internally.
- A valid bit travels with each term through the NUM_STAGE multiplier stages.
- Term counter (0..VECTOR_LEN-1) advances on each valid product reaching the accumulator. Counter 0: acc loads the product; otherwise acc += product. On the product taken at count VECTOR_LEN-1: the final sum (acc+product) is loaded into the result register, out_valid is set, and the counter wraps to 0.
- Stall = out_valid & ~out_ready. While stalled the multiplier pipeline, counter and acc hold; in_ready = ~stall & ~clear.
- Result handshake: out_valid drops on out_valid & out_ready unless a new result loads in the same cycle (then it stays high with new data).
- clear: zeroes counter and acc and invalidates all pipeline valid bits in the same cycle. Any input offered that cycle is not accepted. An already-held result and its out_valid are unaffected.
- reset (any time, including mid-vector): all valid bits, counter, acc and result go to 0. out_valid=0, result=0. in_ready=1 on the first cycle after release.

## Timing
- Throughput: one term per cycle with no stalls. Back-to-back vectors have no bubble.
- Latency: out_valid rises NUM_STAGE+1 cycles after acceptance of a vector's last term.
- out_valid/result are registered. in_ready is combinational from out_valid, out_ready and clear only.
- Reset values: in_ready=1 (clear=0), out_valid=0, result=0.

## Configuration
- PERCEPTRON_MAC_SAT_EN defined: the final sum is clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] before loading result.
- Undefined: result = final sum[OUT_WIDTH-1:0] (two's-complement wrap).
- Latency is identical in both builds.

## Structure
- Package perceptron_pkg: localparams P_WIDTH and ACC_WIDTH as functions of the parameters, a clog2 helper, and the saturate function.
- Sub-module perceptron_mul_pipe:
  - Parametrised NUM_STAGE-deep unsigned×signed multiplier with ce and a valid shift chain.
  - Input registered, then NUM_STAGE-1 product stages, to allow DSP inference.
  - Top level holds the counter, accumulator, result register and handshake.

## Test plan
- Defaults, a=1..16, b=1, out_ready=1 → single result 136, out_valid high exactly 1 cycle, NUM_STAGE+1 cycles after last term.
- a=0xFFFFF, b=-64 for 16 terms → 1024 without SAT_EN; -33554432 with PERCEPTRON_MAC_SAT_EN.
- Two back-to-back vectors (a=2,b=3 ×16, then a=1,b=-1 ×16), out_ready held 0 for 5 cycles at first result → in_ready low for those 5 cycles, results 96 then -16, no term lost.
- clear after 7 terms of a vector, then a=5,b=5 ×16 → single result 400; partial sum discarded.
- reset asserted mid-vector with terms in flight → out_valid=0, result=0 immediately; next full vector a=1,b=1 ×16 gives 16.
- VECTOR_LEN=1, NUM_STAGE=2 → every accepted term produces result a*b after 3 cycles, e.g. a=1000, b=-7 → -7000.
